uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
- Serial UART transmitter. It is the send-side counterpart of the team's UART receiver and runs on the same generated baud clock from the baud-rate generator.
- Accepts one 8-bit byte per handshake and serialises it on `tx` as 8N1: one start bit, 8 data bits LSB first, one stop bit.
- Each bit is held for CLK_PER_BIT baud_clk cycles.
- Sits between the byte producer (host logic, or a loopback from the receiver's `data`) and the serial line.

Parameters:
- CLK_PER_BIT, 2: baud_clk cycles per serial bit. Legal range 1..65535.
- PARITY_ODD, 0: parity sense when the parity feature is compiled in. 0 = even, 1 = odd. Ignored otherwise.

Ports:
- baud_clk  input  1  Generated baud clock. All logic is on its rising edge. This is the block's only clock.
- rst  input  1  Asynchronous, active-high reset.
- tx_start  input  1  Request to send `data_in`. Sampled only in IDLE.
- data_in  input  8  Byte to transmit. Captured on the accepting edge.
- tx  output  1  Serial line. Idles high.
- tx_busy  output  1  High from the accepting edge until the stop bit completes.
- tx_done  output  1  One-cycle pulse marking frame completion.

Behaviour:
- Reset (asynchronous, takes effect immediately, independent of baud_clk):
  - tx=1, tx_busy=0, tx_done=0, state=IDLE.
  - clk_counter=0, bit_index=0, shift register=8'h00.
- Reset mid-frame: the frame is abandoned, `tx` returns high at once, and no tx_done is produced.
- States:
  - IDLE, START, DATA, STOP, plus PARITY when the macro is defined.
  - State register is 2 bits, or 3 bits with parity.
- Counters:
  - clk_counter is 16 bits. It counts 0..CLK_PER_BIT-1 within each bit, then wraps to 0 on every bit transition.
  - bit_index is 3 bits, 0..7. It wraps to 0 when leaving DATA.
- IDLE:
  - tx=1, tx_busy=0.
  - If tx_start=1 at an edge: capture data_in, set tx=0, tx_busy=1, clk_counter=0, go to START.
  - The start bit is driven low from that same edge. Latency is 0 cycles after acceptance.
- START: hold tx=0 for CLK_PER_BIT cycles. On the last cycle, drive tx=shreg[0], bit_index=0, go to DATA.
- DATA:
  - Hold tx=shreg[bit_index] for CLK_PER_BIT cycles each.
  - After the bit-7 period, go to STOP with tx=1 (or to PARITY with tx=parity bit when the macro is defined).
- STOP:
  - Hold tx=1 for CLK_PER_BIT cycles.
  - On the last cycle: go to IDLE, tx_busy=0, tx_done=1 for exactly one cycle.
- Frame length: exactly 10*CLK_PER_BIT cycles from acceptance to the tx_done edge (11*CLK_PER_BIT with parity).
- tx_start while busy: ignored. No queueing, the in-flight frame is unaffected, and data_in changes mid-frame have no effect.
- Back-to-back: tx_start held high through the tx_done cycle is accepted on the next edge (first IDLE cycle). The line gap between frames is then exactly 1 baud_clk cycle of idle-high.
- CLK_PER_BIT=1: every state lasts one cycle; the same rules apply.
- tx_done never coincides with tx_busy=1.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP. It holds tx = (^shreg) ^ PARITY_ODD for CLK_PER_BIT cycles.
  - Frame is 11 bits (8E1 or 8O1).
- Undefined: no PARITY state, no parity logic, 8N1 framing. PARITY_ODD has no effect.

Test Plan:
- Reset then idle: assert rst for 3 cycles, release, 10 idle cycles → tx=1, tx_busy=0, tx_done=0 throughout.
- Single frame, CLK_PER_BIT=2, data_in=8'hA5, pulse tx_start one cycle:
  - tx, 2 cycles per bit: 0,1,0,1,0,0,1,0,1,1.
  - tx_busy high for 20 cycles.
  - tx_done single pulse on the 20th edge after acceptance.
- Busy rejection: start 8'h3C, then pulse tx_start with data_in=8'hFF at cycle 7 → serialised bits remain 0,0,1,1,1,1,0,0 (3C LSB first); exactly one tx_done.
- Back-to-back, tx_start held high, data 8'h01 then 8'h80, CLK_PER_BIT=2 → two frames separated by exactly 1 idle-high cycle; two tx_done pulses 21 cycles apart.
- Reset mid-frame: assert rst during DATA bit 3 of 8'h55 → tx=1 and tx_busy=0 immediately (before the next edge); no tx_done. A subsequent 8'h55 send is a correct full frame.
- Parity (UART_TX_PARITY_EN defined, PARITY_ODD=0):
  - 8'hA5 → parity bit 0; frame 22 cycles.
  - 8'h07 → parity bit 1.
  - With PARITY_ODD=1, 8'hA5 → parity bit 1.

Source files
------------

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter on the generated baud clock. Each bit lasts CLK_PER_BIT cycles.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd when PARITY_ODD=1) before the stop bit.
module uart_transmitter #(
  parameter int CLK_PER_BIT = 2,
  parameter bit PARITY_ODD  = 1'b0
) (
  input  logic       baud_clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [15:0] CNT_LAST = 16'(CLK_PER_BIT - 1);

  state_t      state;
  logic [15:0] clk_counter;
  logic [2:0]  bit_index;
  logic [7:0]  shreg;
  logic        bit_end;

  // Only called when the parity state is compiled in.
  function automatic logic parity_bit(input logic [7:0] b);
    return (^b) ^ PARITY_ODD;
  endfunction

  assign bit_end = (clk_counter == CNT_LAST);

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      clk_counter <= 16'd0;
      bit_index   <= 3'd0;
      shreg       <= 8'h00;
      tx          <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          tx          <= 1'b1;
          tx_busy     <= 1'b0;
          clk_counter <= 16'd0;
          bit_index   <= 3'd0;
          // Start bit goes out on the accepting edge itself.
          if (tx_start) begin
            shreg   <= data_in;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            clk_counter <= 16'd0;
            bit_index   <= 3'd0;
            tx          <= shreg[0];
            state       <= DATA;
          end else begin
            clk_counter <= clk_counter + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_counter <= 16'd0;
            if (bit_index == 3'd7) begin
              bit_index <= 3'd0;
`ifdef UART_TX_PARITY_EN
              tx    <= parity_bit(shreg);
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_index <= bit_index + 3'd1;
              tx        <= shreg[bit_index + 3'd1];
            end
          end else begin
            clk_counter <= clk_counter + 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            clk_counter <= 16'd0;
            tx          <= 1'b1;
            state       <= STOP;
          end else begin
            clk_counter <= clk_counter + 16'd1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            clk_counter <= 16'd0;
            tx          <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b1;
            state       <= IDLE;
          end else begin
            clk_counter <= clk_counter + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with CLK_PER_BIT=2; an odd-parity instance runs alongside.
// Frame length follows UART_TX_PARITY_EN.
module tb_uart_transmitter;
  localparam int CPB = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       baud_clk = 1'b0;
  logic       rst      = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] data_in  = 8'h00;
  logic       tx, tx_busy, tx_done;
  logic       tx_o, busy_o, done_o;

  int tests = 0, fails = 0, cyc = 0, last_done = 0, prev_done = 0;

  uart_transmitter #(.CLK_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
    .baud_clk(baud_clk), .rst(rst), .tx_start(tx_start), .data_in(data_in),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_transmitter #(.CLK_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
    .baud_clk(baud_clk), .rst(rst), .tx_start(tx_start), .data_in(data_in),
    .tx(tx_o), .tx_busy(busy_o), .tx_done(done_o)
  );

  always #5 baud_clk = ~baud_clk;
  always @(posedge baud_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the tx_done edge.
  task automatic send(input logic [7:0] d, input logic p_even, input logic p_odd,
                      input int poke_at, input bit hold);
    logic [10:0] f;
    logic [10:0] f_par;
    logic [10:0] f_np;
    int b;
    f_par = {1'b1, p_even, d, 1'b0};
    f_np  = {2'b11, d, 1'b0};
    f = (NB == 11) ? f_par : f_np;
    tx_start = 1'b1;
    data_in  = d;
    @(posedge baud_clk);
    #1;
    if (!hold) tx_start = 1'b0;
    for (int k = 0; k < NB * CPB; k++) begin
      @(negedge baud_clk);
      b = k / CPB;
      check($sformatf("tx_%02h_bit%0d", d, b), tx, f[b]);
      check($sformatf("tx_odd_%02h_bit%0d", d, b), tx_o,
            (NB == 11 && b == 9) ? p_odd : f[b]);
      check("busy_in_frame", tx_busy, 1);
      check("busy_odd_in_frame", busy_o, 1);
      check("done_early", tx_done, 0);
      if (poke_at >= 0 && k == poke_at) begin
        tx_start = 1'b1;
        data_in  = 8'hFF;
      end else if (poke_at >= 0 && k == poke_at + 1) begin
        tx_start = 1'b0;
        data_in  = d;
      end
    end
    @(negedge baud_clk);
    check("done_at_end", tx_done, 1);
    check("done_odd_at_end", done_o, 1);
    check("busy_at_done", tx_busy, 0);
    check("tx_idle_at_done", tx, 1);
    prev_done = last_done;
    last_done = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge baud_clk);
    @(negedge baud_clk);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    rst = 1'b0;
    repeat (10) begin
      @(negedge baud_clk);
      check("idle_tx", tx, 1);
      check("idle_busy", tx_busy, 0);
      check("idle_done", tx_done, 0);
    end

    send(8'hA5, 1'b0, 1'b1, -1, 1'b0);
    @(negedge baud_clk);
    check("done_one_cycle", tx_done, 0);

    send(8'h3C, 1'b0, 1'b1, 6, 1'b0);
    @(negedge baud_clk);
    check("busy_reject_single_done", tx_done, 0);
    check("busy_reject_idle", tx_busy, 0);

    send(8'h01, 1'b1, 1'b0, -1, 1'b1);
    send(8'h80, 1'b1, 1'b0, -1, 1'b0);
    check("b2b_done_spacing", last_done - prev_done, NB * CPB + 1);

    send(8'h07, 1'b1, 1'b0, -1, 1'b0);

    // Abort 8'h55 in data bit 3 (a 0 bit) and confirm the line releases asynchronously.
    tx_start = 1'b1;
    data_in  = 8'h55;
    @(posedge baud_clk);
    #1;
    tx_start = 1'b0;
    repeat (9) @(negedge baud_clk);
    check("pre_rst_bit3", tx, 0);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_tx", tx, 1);
    check("async_rst_busy", tx_busy, 0);
    repeat (2) @(posedge baud_clk);
    @(negedge baud_clk);
    rst = 1'b0;
    n = 0;
    repeat (25) begin
      @(negedge baud_clk);
      if (tx_done) n++;
    end
    check("no_done_after_abort", n, 0);
    check("idle_after_abort", tx, 1);
    send(8'h55, 1'b0, 1'b1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
